multi_channel_watchdog: RTL and testbench
=========================================

# multi_channel_watchdog

Parametrised, multi-channel watchdog for the AM radio FPGA control plane. It supervises NUM_CH independent heartbeat sources, such as the DDS/carrier control loop, the SCPI command handler and the DMA feeder. Each channel has its own timeout, an early-warning threshold and a minimum kick interval for windowed supervision. Any channel trip raises a global RF kill line that gates the modulator output.

## Interface
Parameters:
- NUM_CH, 4: number of supervised channels.
- CNT_W, 32: per-channel counter width.
- TIMEOUT, 100_000_000: enabled cycles without a valid kick before trip. Range 2..2^CNT_W-1.
- WARN_AT, 75_000_000: counter value at which `warning` asserts. Must satisfy WINDOW_MIN < WARN_AT < TIMEOUT.
- WINDOW_MIN, 0: minimum counter value for a legal kick. A kick with counter < WINDOW_MIN is a window violation. 0 disables early-kick detection.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  NUM_CH  per-channel supervise enable.
- heartbeat  in  NUM_CH  per-channel kick input. Rising-edge detected.
- force_trigger  in  1  trip all channels, regardless of enable.
- clear  in  1  clear all trips and restart counting.
- warning  out  NUM_CH  counter ≥ WARN_AT and channel not tripped.
- triggered  out  NUM_CH  sticky trip flag.
- early_kick  out  NUM_CH  sticky flag: the trip was caused by a window violation.
- any_triggered  out  1  OR of `triggered`; drives RF kill.
- trip_count  out  8  total trip events, saturating at 255.

## Operation
- Per-channel FSM states:
  - IDLE: enable low. Counter held at 0.
  - COUNT
  - WARN: counter ≥ WARN_AT.
  - TRIPPED
- Kick detection: kick = heartbeat & ~hb_q, where hb_q is the registered heartbeat (reset 0). A heartbeat held high produces exactly one kick.
- IDLE → COUNT on an edge with enable high. That edge increments the counter to 1.
- In COUNT/WARN, each enabled edge applies the first matching rule:
  - valid kick (counter ≥ WINDOW_MIN): counter ← 0, warning ← 0, state COUNT.
  - early kick (WINDOW_MIN > 0 and counter < WINDOW_MIN): → TRIPPED, triggered ← 1, early_kick ← 1.
  - counter == TIMEOUT-1 and no kick: → TRIPPED, triggered ← 1.
  - otherwise: counter ← counter+1. Enter WARN (warning ← 1) on the edge where the new value equals WARN_AT.
- enable low in COUNT/WARN: → IDLE, counter ← 0, warning ← 0.
- TRIPPED: counter frozen, warning ← 0. Leaves only on clear or rst. enable low does not clear `triggered`.
- Global priority per edge: rst > force_trigger > clear > per-channel rules.
  - force_trigger: every channel not already TRIPPED → TRIPPED with triggered ← 1. early_kick is unchanged.
  - clear: triggered, early_kick, warning and counters ← 0. Each channel → COUNT if enable is high, else IDLE. hb_q still updates.
- trip_count: increments by 1 on any edge where at least one channel newly enters TRIPPED. Multiple simultaneous trips count as one. Saturates at 255. Cleared only by rst; `clear` leaves it unchanged.
- Counter arithmetic is unsigned CNT_W-bit. The counter never exceeds TIMEOUT-1, so no wrap-around.

## Timing
- Reset values: warning = 0, triggered = 0, early_kick = 0, any_triggered = 0, trip_count = 0. All counters = 0, all states IDLE, hb_q = 0.
- rst asserted mid-operation takes effect on the next edge and overrides force_trigger and clear.
- With enable high and no kicks:
  - warning rises at the WARN_AT-th enabled edge.
  - triggered rises, and warning falls, at the TIMEOUT-th enabled edge.
- Kick latency: the counter is 0 after the edge that samples the heartbeat rising edge. Warning drops at the same edge.
- force_trigger/clear latency: 1 edge.
- any_triggered is a combinational OR of registered `triggered` bits, so it adds zero additional latency.
- A heartbeat rising edge in the same cycle as enable rising is a kick evaluated with counter = 0. It is early if WINDOW_MIN > 0.

## Test plan
Common parameters: NUM_CH=2, CNT_W=8, TIMEOUT=10, WARN_AT=6, WINDOW_MIN=3.
- Release rst, hold enable=2'b01, no heartbeats:
  - warning[0] rises at the 6th edge.
  - triggered[0]=1, warning[0]=0, any_triggered=1 and trip_count=1 at the 10th edge.
  - Channel 1 stays at 0 throughout.
- enable=2'b11, kick ch0 every 5 cycles for 100 cycles -> ch0 warning and triggered stay 0; ch1 trips at the 10th edge.
- Kick ch0 when counter=2 -> triggered[0]=1 and early_kick[0]=1 next edge; trip_count=1.
- Hold heartbeat[0]=1 for 30 cycles from counter=4 -> one kick only; trips 10 edges later.
- Apply these in sequence:
  1. force_trigger and clear asserted together -> both triggered=1, trip_count increments once.
  2. clear alone -> all flags 0, counters restart.
  3. enable low at counter=7 -> warning 0, counter 0.
  4. rst while tripped -> all outputs 0, trip_count=0.

Source files
------------

// File: rtl/multi_channel_watchdog.sv
// Multi-channel watchdog: per-channel timeout, early warning and windowed kick
// supervision, with a global trip OR used as the RF kill line.
module multi_channel_watchdog #(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = 32,
  parameter int unsigned TIMEOUT    = 100_000_000,
  parameter int unsigned WARN_AT    = 75_000_000,
  parameter int unsigned WINDOW_MIN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] heartbeat,
  input  logic              force_trigger,
  input  logic              clear,
  output logic [NUM_CH-1:0] warning,
  output logic [NUM_CH-1:0] triggered,
  output logic [NUM_CH-1:0] early_kick,
  output logic              any_triggered,
  output logic [7:0]        trip_count
);

  typedef enum logic [1:0] {IDLE, COUNT, WARN, TRIPPED} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WARN_V     = CNT_W'(WARN_AT);
  localparam logic [CNT_W-1:0] WMIN_V     = CNT_W'(WINDOW_MIN);

  state_t           state_q [NUM_CH];
  state_t           state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] early_q, early_d, hb_q, kick, new_trip, too_early;

  // With WINDOW_MIN == 0 no kick can ever be early, so skip the compare entirely.
  generate
    if (WINDOW_MIN == 0) begin : g_no_window
      assign too_early = '0;
    end else begin : g_window
      for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign too_early[g] = (cnt_q[g] < WMIN_V);
      end
    end
  endgenerate

  always_comb begin
    kick     = heartbeat & ~hb_q;
    new_trip = '0;
    early_d  = early_q;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (force_trigger) begin
        if (state_q[i] != TRIPPED) begin
          state_d[i]  = TRIPPED;
          new_trip[i] = 1'b1;
        end
      end else if (clear) begin
        state_d[i] = enable[i] ? COUNT : IDLE;
        cnt_d[i]   = '0;
        early_d[i] = 1'b0;
      end else if (state_q[i] != TRIPPED) begin
        // IDLE shares the COUNT rules: its counter is 0, so an edge with enable
        // high either kicks at counter 0 or counts to 1.
        if (!enable[i]) begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end else if (kick[i] && !too_early[i]) begin
          state_d[i] = COUNT;
          cnt_d[i]   = '0;
        end else if (kick[i]) begin
          state_d[i]  = TRIPPED;
          early_d[i]  = 1'b1;
          new_trip[i] = 1'b1;
        end else if (cnt_q[i] == TIMEOUT_M1) begin
          state_d[i]  = TRIPPED;
          new_trip[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
          if (cnt_d[i] == WARN_V) begin
            state_d[i] = WARN;
          end else if (state_q[i] == IDLE) begin
            state_d[i] = COUNT;
          end
        end
      end
    end
  end

  always_comb begin
    warning   = '0;
    triggered = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      warning[i]   = (state_q[i] == WARN);
      triggered[i] = (state_q[i] == TRIPPED);
    end
  end

  assign early_kick    = early_q;
  assign any_triggered = |triggered;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      early_q    <= '0;
      hb_q       <= '0;
      trip_count <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      early_q <= early_d;
      hb_q    <= heartbeat;
      // Simultaneous trips on one edge count as a single event.
      if (|new_trip && trip_count != 8'hFF) begin
        trip_count <= trip_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Directed bench for multi_channel_watchdog: a counter-level behavioural model
// checked every cycle, plus hand-computed literal expectations.
module tb_multi_channel_watchdog;

  localparam int NUM_CH     = 2;
  localparam int CNT_W      = 8;
  localparam int TIMEOUT    = 10;
  localparam int WARN_AT    = 6;
  localparam int WINDOW_MIN = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] enable;
  logic [NUM_CH-1:0] heartbeat;
  logic              force_trigger;
  logic              clear;
  logic [NUM_CH-1:0] warning;
  logic [NUM_CH-1:0] triggered;
  logic [NUM_CH-1:0] early_kick;
  logic              any_triggered;
  logic [7:0]        trip_count;

  int checks = 0;
  int errors = 0;

  int m_cnt  [NUM_CH];
  bit m_trip [NUM_CH];
  bit m_early[NUM_CH];
  bit [NUM_CH-1:0] m_hbp;
  int m_tc;

  multi_channel_watchdog #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT),
    .WARN_AT(WARN_AT), .WINDOW_MIN(WINDOW_MIN)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .heartbeat(heartbeat),
    .force_trigger(force_trigger), .clear(clear), .warning(warning),
    .triggered(triggered), .early_kick(early_kick),
    .any_triggered(any_triggered), .trip_count(trip_count)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Spec-level model: a counter per channel plus sticky flags.
  task automatic modelStep();
    bit any_new;
    any_new = 1'b0;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_cnt[i] = 0; m_trip[i] = 0; m_early[i] = 0;
      end
      m_hbp = '0;
      m_tc  = 0;
      return;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (force_trigger) begin
        if (!m_trip[i]) begin m_trip[i] = 1; any_new = 1; end
      end else if (clear) begin
        m_trip[i] = 0; m_early[i] = 0; m_cnt[i] = 0;
      end else if (!m_trip[i]) begin
        if (!enable[i]) m_cnt[i] = 0;
        else if (heartbeat[i] && !m_hbp[i]) begin
          if (m_cnt[i] < WINDOW_MIN) begin
            m_trip[i] = 1; m_early[i] = 1; any_new = 1;
          end else m_cnt[i] = 0;
        end else if (m_cnt[i] == TIMEOUT - 1) begin
          m_trip[i] = 1; any_new = 1;
        end else m_cnt[i]++;
      end
    end
    if (any_new && m_tc < 255) m_tc++;
    m_hbp = heartbeat;
  endtask

  task automatic checkOutput();
    bit [NUM_CH-1:0] e_warn, e_trip, e_early;
    for (int i = 0; i < NUM_CH; i++) begin
      e_warn[i]  = !m_trip[i] && (m_cnt[i] >= WARN_AT);
      e_trip[i]  = m_trip[i];
      e_early[i] = m_early[i];
    end
    checkVal("model warning",       warning,       e_warn);
    checkVal("model triggered",     triggered,     e_trip);
    checkVal("model early_kick",    early_kick,    e_early);
    checkVal("model any_triggered", any_triggered, |e_trip);
    checkVal("model trip_count",    trip_count,    m_tc);
  endtask

  // Drive at the falling edge, advance one rising edge, check at the next fall.
  task automatic applyStimulus(input bit [NUM_CH-1:0] en, input bit [NUM_CH-1:0] hb,
                               input bit ft, input bit cl, input bit r);
    enable = en; heartbeat = hb; force_trigger = ft; clear = cl; rst = r;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; enable = '0; heartbeat = '0; force_trigger = 1'b0; clear = 1'b0;
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, 0, 0, 1);
    applyStimulus(2'b00, 2'b00, 0, 0, 1);
    checkVal("reset triggered", triggered, 0);
    checkVal("reset warning", warning, 0);
    checkVal("reset trip_count", trip_count, 0);

    // Free-running timeout on channel 0 only
    for (int e = 1; e <= 10; e++) begin
      applyStimulus(2'b01, 2'b00, 0, 0, 0);
      if (e == 5) checkVal("warn not before 6th edge", warning, 2'b00);
      if (e == 6) checkVal("warn at 6th edge", warning, 2'b01);
      if (e == 9) checkVal("no trip at 9th edge", triggered, 2'b00);
      if (e == 10) begin
        checkVal("trip at 10th edge", triggered, 2'b01);
        checkVal("warn drops at trip", warning, 2'b00);
        checkVal("any_triggered at trip", any_triggered, 1);
        checkVal("trip_count first", trip_count, 1);
      end
    end

    // Periodic kicks keep ch0 alive while ch1 times out
    applyStimulus(2'b11, 2'b00, 0, 1, 0);
    checkVal("clear releases", triggered, 2'b00);
    for (int j = 0; j < 100; j++) begin
      applyStimulus(2'b11, (j % 5 == 4) ? 2'b01 : 2'b00, 0, 0, 0);
      if (j == 9) checkVal("ch1 trips at 10th edge", triggered, 2'b10);
    end
    for (int j = 0; j < 12; j++) begin
      applyStimulus(2'b11, (j % 4 == 3) ? 2'b01 : 2'b00, 0, 0, 0);
    end
    checkVal("kick at window boundary legal", triggered[0], 0);

    // Early kick at counter 2
    applyStimulus(2'b00, 2'b00, 0, 0, 1);
    applyStimulus(2'b01, 2'b00, 0, 0, 0);
    applyStimulus(2'b01, 2'b00, 0, 0, 0);
    applyStimulus(2'b01, 2'b01, 0, 0, 0);
    checkVal("early trip", triggered, 2'b01);
    checkVal("early flag", early_kick, 2'b01);
    checkVal("early trip_count", trip_count, 1);
    applyStimulus(2'b01, 2'b00, 0, 0, 0);

    // Held heartbeat counts as one kick
    applyStimulus(2'b01, 2'b00, 0, 1, 0);
    checkVal("clear drops early flag", early_kick, 2'b00);
    for (int e = 0; e < 4; e++) applyStimulus(2'b01, 2'b00, 0, 0, 0);
    for (int k = 0; k < 30; k++) begin
      applyStimulus(2'b01, 2'b01, 0, 0, 0);
      if (k == 9) begin
        checkVal("held hb no retrip yet", triggered, 2'b00);
        checkVal("held hb warning", warning, 2'b01);
      end
      if (k == 10) begin
        checkVal("held hb trips 10 later", triggered, 2'b01);
        checkVal("held hb trip_count", trip_count, 2);
      end
    end
    applyStimulus(2'b01, 2'b00, 0, 0, 0);

    // force + clear together: force wins
    applyStimulus(2'b01, 2'b00, 1, 1, 0);
    checkVal("force over clear", triggered, 2'b11);
    checkVal("force counts once", trip_count, 3);
    applyStimulus(2'b11, 2'b00, 0, 1, 0);
    checkVal("clear alone triggered", triggered, 2'b00);
    checkVal("clear keeps trip_count", trip_count, 3);
    for (int e = 0; e < 7; e++) applyStimulus(2'b11, 2'b00, 0, 0, 0);
    checkVal("warn at counter 7", warning, 2'b11);
    applyStimulus(2'b00, 2'b00, 0, 0, 0);
    checkVal("enable low drops warning", warning, 2'b00);
    for (int e = 1; e <= 10; e++) begin
      applyStimulus(2'b11, 2'b00, 0, 0, 0);
      if (e == 5) checkVal("restart from 0", warning, 2'b00);
    end
    checkVal("both timeout", triggered, 2'b11);
    checkVal("trip_count 4", trip_count, 4);
    applyStimulus(2'b11, 2'b00, 1, 1, 1);
    checkVal("rst overrides triggered", triggered, 2'b00);
    checkVal("rst clears trip_count", trip_count, 0);

    // Saturation of trip_count
    for (int n = 0; n < 256; n++) begin
      applyStimulus(2'b00, 2'b00, 1, 0, 0);
      applyStimulus(2'b00, 2'b00, 0, 1, 0);
    end
    checkVal("trip_count saturates", trip_count, 255);
    applyStimulus(2'b00, 2'b00, 1, 0, 0);
    checkVal("trip_count stays 255", trip_count, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
